// File: rtl/snk_video_pkg.sv
// snk_video_pkg
//   Shared definitions for the SNK video timing generator.
//   - timing_cfg_t   : one raster geometry (totals, active area, sync placement)
//   - ATHENA_TIMING  : raster used by Athena
//   - TNKIII_TIMING  : raster used by TNK III (same crystal and raster as Athena)
//   - sat_add_clamp(): base + signed offset, saturated into [lo, hi]
package snk_video_pkg;

    typedef struct packed {
        int h_total;
        int h_active;
        int h_sync_start;
        int h_sync_len;
        int v_total;
        int v_active;
        int v_sync_start;
        int v_sync_len;
    } timing_cfg_t;

    localparam timing_cfg_t ATHENA_TIMING = '{
        h_total      : 424,
        h_active     : 288,
        h_sync_start : 320,
        h_sync_len   : 32,
        v_total      : 262,
        v_active     : 224,
        v_sync_start : 236,
        v_sync_len   : 3
    };

    localparam timing_cfg_t TNKIII_TIMING = '{
        h_total      : 424,
        h_active     : 288,
        h_sync_start : 320,
        h_sync_len   : 32,
        v_total      : 262,
        v_active     : 224,
        v_sync_start : 236,
        v_sync_len   : 3
    };

    // Signed add followed by saturation. The sum can go below lo when a
    // negative offset is applied to a sync start that sits near the end of
    // the active area, so the arithmetic is done signed.
    function automatic int sat_add_clamp(input int base, input int offset,
                                         input int lo, input int hi);
        int sum;
        sum = base + offset;
        if (sum < lo) begin
            return lo;
        end
        if (sum > hi) begin
            return hi;
        end
        return sum;
    endfunction

endpackage

// File: rtl/snk_video_timing_gen_counter.sv
// snk_sync_counter
//   Generic wrap counter: counts 0..MAX while en is high and wraps to 0.
//   Ports:
//     clk      : clock
//     rst_n    : synchronous active-low reset
//     en       : count enable for this cycle
//     cnt      : registered count
//     cnt_next : value cnt takes at the next clk edge (lets the parent decode
//                outputs in the same cycle the counter moves)
//     tc       : terminal count, cnt == MAX
module snk_sync_counter #(
    parameter int MAX = 423,
    parameter int W   = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         tc
);

    assign tc = (cnt == W'(MAX));

    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = tc ? '0 : cnt + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/snk_video_timing_gen.sv
// snk_video_timing_gen
//   Pixel-enable-qualified raster timing for SNK tile/sprite boards.
//   Produces raw counters, blanking, sync, display enable, flip-corrected
//   screen coordinates, line/frame strobes and a vblank interrupt strobe.
//   Sync position can be trimmed at run time; the trim only takes effect at
//   a frame boundary so a frame is never torn.
//   Ports:
//     clk         : core clock
//     VIDEO_RSTn  : synchronous active-low reset
//     ce_pix      : pixel clock enable, one clk wide
//     flip        : screen invert, sampled on every ce
//     hs_adj      : signed hsync offset in pixels (-8..+7)
//     vs_adj      : signed vsync offset in lines (-4..+3)
//     hcnt, vcnt  : raw raster position
//     scr_x/scr_y : flip-corrected position inside the active area
//     hblank/vblank/hsync/vsync/disp : registered raster decodes
//     line_start/frame_start/vbl_irq : one-clk strobes
//     frame_cnt   : frame counter, wraps at 256
module snk_video_timing_gen
    import snk_video_pkg::*;
#(
    parameter int H_TOTAL      = ATHENA_TIMING.h_total,
    parameter int H_ACTIVE     = ATHENA_TIMING.h_active,
    parameter int H_SYNC_START = ATHENA_TIMING.h_sync_start,
    parameter int H_SYNC_LEN   = ATHENA_TIMING.h_sync_len,
    parameter int V_TOTAL      = ATHENA_TIMING.v_total,
    parameter int V_ACTIVE     = ATHENA_TIMING.v_active,
    parameter int V_SYNC_START = ATHENA_TIMING.v_sync_start,
    parameter int V_SYNC_LEN   = ATHENA_TIMING.v_sync_len,
    parameter int HW           = $clog2(H_TOTAL),
    parameter int VW           = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          VIDEO_RSTn,
    input  logic          ce_pix,
    input  logic          flip,
    input  logic [3:0]    hs_adj,
    input  logic [2:0]    vs_adj,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic [HW-1:0] scr_x,
    output logic [VW-1:0] scr_y,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          disp,
    output logic          line_start,
    output logic          frame_start,
    output logic          vbl_irq,
    output logic [7:0]    frame_cnt
);

    if (H_ACTIVE + H_SYNC_LEN > H_TOTAL) begin : g_bad_h_geometry
        $error("snk_video_timing_gen: H_ACTIVE + H_SYNC_LEN exceeds H_TOTAL");
    end
    if (V_ACTIVE + V_SYNC_LEN > V_TOTAL) begin : g_bad_v_geometry
        $error("snk_video_timing_gen: V_ACTIVE + V_SYNC_LEN exceeds V_TOTAL");
    end

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          h_tc;
    logic          v_tc;

    snk_sync_counter #(
        .MAX (H_TOTAL - 1),
        .W   (HW)
    ) u_hcnt (
        .clk      (clk),
        .rst_n    (VIDEO_RSTn),
        .en       (ce_pix),
        .cnt      (hcnt),
        .cnt_next (h_next),
        .tc       (h_tc)
    );

    snk_sync_counter #(
        .MAX (V_TOTAL - 1),
        .W   (VW)
    ) u_vcnt (
        .clk      (clk),
        .rst_n    (VIDEO_RSTn),
        .en       (ce_pix & h_tc),
        .cnt      (vcnt),
        .cnt_next (v_next),
        .tc       (v_tc)
    );

    // Shadowed sync trims, only reloaded on the last pixel of a frame.
    logic signed [3:0] hs_sh;
    logic signed [2:0] vs_sh;

    logic [HW-1:0] hs_start;
    logic [HW:0]   hs_end;
    logic [VW-1:0] vs_start;
    logic [VW:0]   vs_end;

    assign hs_start = HW'(sat_add_clamp(H_SYNC_START, int'(hs_sh),
                                        H_ACTIVE, H_TOTAL - H_SYNC_LEN));
    assign vs_start = VW'(sat_add_clamp(V_SYNC_START, int'(vs_sh),
                                        V_ACTIVE, V_TOTAL - V_SYNC_LEN));
    // One extra bit: the window end may equal the total.
    assign hs_end   = {1'b0, hs_start} + (HW+1)'(H_SYNC_LEN);
    assign vs_end   = {1'b0, vs_start} + (VW+1)'(V_SYNC_LEN);

    // Everything below is decoded from the position the counters move to on
    // this edge, so the registered outputs stay coherent with hcnt/vcnt.
    logic          hblank_d;
    logic          vblank_d;
    logic          hsync_d;
    logic          vs_after_start;
    logic          vs_before_end;
    logic          vsync_d;
    logic [HW-1:0] scr_x_d;
    logic [VW-1:0] scr_y_d;
    logic          line_start_d;

    assign hblank_d = (h_next >= HW'(H_ACTIVE));
    assign vblank_d = (v_next >= VW'(V_ACTIVE));
    assign hsync_d  = (h_next >= hs_start) && ({1'b0, h_next} < hs_end);

    // vsync edges land at hcnt == hs_start of the start and end lines, so
    // the window is [vs_start:hs_start, vs_end:hs_start) in raster order.
    // When vs_end equals V_TOTAL the window simply runs to the frame end.
    assign vs_after_start = (v_next > vs_start) ||
                            ((v_next == vs_start) && (h_next >= hs_start));
    assign vs_before_end  = ({1'b0, v_next} < vs_end) ||
                            (({1'b0, v_next} == vs_end) && (h_next < hs_start));
    assign vsync_d        = vs_after_start && vs_before_end;

    assign scr_x_d = (flip && !hblank_d) ? HW'(H_ACTIVE - 1) - h_next : h_next;
    assign scr_y_d = (flip && !vblank_d) ? VW'(V_ACTIVE - 1) - v_next : v_next;

    assign line_start_d = (h_next == '0);

    always_ff @(posedge clk) begin
        if (!VIDEO_RSTn) begin
            scr_x       <= '0;
            scr_y       <= '0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            disp        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vbl_irq     <= 1'b0;
            frame_cnt   <= 8'd0;
            hs_sh       <= '0;
            vs_sh       <= '0;
        end else begin
            // Strobes drop on the clk after they fire, independent of ce gaps.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vbl_irq     <= 1'b0;
            if (ce_pix) begin
                scr_x       <= scr_x_d;
                scr_y       <= scr_y_d;
                hblank      <= hblank_d;
                vblank      <= vblank_d;
                hsync       <= hsync_d;
                vsync       <= vsync_d;
                disp        <= !hblank_d && !vblank_d;
                line_start  <= line_start_d;
                frame_start <= line_start_d && (v_next == '0);
                vbl_irq     <= line_start_d && (v_next == VW'(V_ACTIVE));
                if (h_tc && v_tc) begin
                    hs_sh     <= $signed(hs_adj);
                    vs_sh     <= $signed(vs_adj);
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snk_video_timing_gen.sv
module tb_snk_video_timing_gen;

    // Small raster for the second instance so whole frames fit in the run.
    localparam int S_HT  = 40;
    localparam int S_HA  = 24;
    localparam int S_HSS = 30;
    localparam int S_HSL = 4;
    localparam int S_VT  = 20;
    localparam int S_VA  = 14;
    localparam int S_VSS = 16;
    localparam int S_VSL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;
    logic [1:0] ce;
    logic [1:0] flip;
    logic [3:0] hs_adj [2];
    logic [2:0] vs_adj [2];

    logic [1:0] hblank, vblank, hsync, vsync, disp, line_start, frame_start, vbl_irq;
    logic [8:0] d0_hcnt, d0_vcnt, d0_scr_x, d0_scr_y;
    logic [7:0] d0_fc, d1_fc;
    logic [5:0] d1_hcnt, d1_scr_x;
    logic [4:0] d1_vcnt, d1_scr_y;

    snk_video_timing_gen u_dut0 (
        .clk         (clk),
        .VIDEO_RSTn  (rst_n[0]),
        .ce_pix      (ce[0]),
        .flip        (flip[0]),
        .hs_adj      (hs_adj[0]),
        .vs_adj      (vs_adj[0]),
        .hcnt        (d0_hcnt),
        .vcnt        (d0_vcnt),
        .scr_x       (d0_scr_x),
        .scr_y       (d0_scr_y),
        .hblank      (hblank[0]),
        .vblank      (vblank[0]),
        .hsync       (hsync[0]),
        .vsync       (vsync[0]),
        .disp        (disp[0]),
        .line_start  (line_start[0]),
        .frame_start (frame_start[0]),
        .vbl_irq     (vbl_irq[0]),
        .frame_cnt   (d0_fc)
    );

    snk_video_timing_gen #(
        .H_TOTAL      (S_HT),
        .H_ACTIVE     (S_HA),
        .H_SYNC_START (S_HSS),
        .H_SYNC_LEN   (S_HSL),
        .V_TOTAL      (S_VT),
        .V_ACTIVE     (S_VA),
        .V_SYNC_START (S_VSS),
        .V_SYNC_LEN   (S_VSL)
    ) u_dut1 (
        .clk         (clk),
        .VIDEO_RSTn  (rst_n[1]),
        .ce_pix      (ce[1]),
        .flip        (flip[1]),
        .hs_adj      (hs_adj[1]),
        .vs_adj      (vs_adj[1]),
        .hcnt        (d1_hcnt),
        .vcnt        (d1_vcnt),
        .scr_x       (d1_scr_x),
        .scr_y       (d1_scr_y),
        .hblank      (hblank[1]),
        .vblank      (vblank[1]),
        .hsync       (hsync[1]),
        .vsync       (vsync[1]),
        .disp        (disp[1]),
        .line_start  (line_start[1]),
        .frame_start (frame_start[1]),
        .vbl_irq     (vbl_irq[1]),
        .frame_cnt   (d1_fc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Geometry per instance.
    int HT [2], HA [2], HSS [2], HSL [2], VT [2], VA [2], VSS [2], VSL [2];

    // Reference model: a linear pixel index within the frame plus frame number.
    int q [2], f [2], hsh [2], vsh [2];
    bit fresh [2], last_ce [2], flip_l [2];

    // Stimulus control.
    int gap [2], gmax [2];
    bit adj_rand [2];

    // Per-frame strobe bookkeeping for the small instance.
    int ls_cnt = 0, vi_cnt = 0;
    bit armed = 0;

    string nm [13] = '{"hcnt", "vcnt", "scr_x", "scr_y", "hblank", "vblank", "hsync",
                       "vsync", "disp", "line_start", "frame_start", "vbl_irq", "frame_cnt"};

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        if (!rst_n[i]) begin
            q[i] = 0; f[i] = 0; hsh[i] = 0; vsh[i] = 0;
            fresh[i] = 1; last_ce[i] = 0; flip_l[i] = 0;
        end else if (ce[i]) begin
            if (q[i] == HT[i] * VT[i] - 1) begin
                q[i]   = 0;
                f[i]   = (f[i] + 1) % 256;
                hsh[i] = int'($signed(hs_adj[i]));
                vsh[i] = int'($signed(vs_adj[i]));
            end else begin
                q[i]++;
            end
            fresh[i] = 0; last_ce[i] = 1; flip_l[i] = flip[i];
        end else begin
            last_ce[i] = 0;
        end
    endtask

    task automatic check_dut(input int i);
        int obs [13];
        int exp [13];
        int h, v, hs, vs, ss, se;
        h  = q[i] % HT[i];
        v  = q[i] / HT[i];
        hs = clampi(HSS[i] + hsh[i], HA[i], HT[i] - HSL[i]);
        vs = clampi(VSS[i] + vsh[i], VA[i], VT[i] - VSL[i]);
        ss = vs * HT[i] + hs;
        se = (vs + VSL[i]) * HT[i] + hs;
        if (fresh[i]) begin
            exp = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        end else begin
            exp[0]  = h;
            exp[1]  = v;
            exp[2]  = (flip_l[i] && h < HA[i]) ? HA[i] - 1 - h : h;
            exp[3]  = (flip_l[i] && v < VA[i]) ? VA[i] - 1 - v : v;
            exp[4]  = int'(h >= HA[i]);
            exp[5]  = int'(v >= VA[i]);
            exp[6]  = int'(h >= hs && h < hs + HSL[i]);
            exp[7]  = int'(q[i] >= ss && q[i] < se);
            exp[8]  = int'(h < HA[i] && v < VA[i]);
            exp[9]  = int'(last_ce[i] && h == 0);
            exp[10] = int'(last_ce[i] && q[i] == 0);
            exp[11] = int'(last_ce[i] && h == 0 && v == VA[i]);
            exp[12] = f[i];
        end
        if (i == 0) begin
            obs[0] = int'(d0_hcnt);  obs[1] = int'(d0_vcnt);
            obs[2] = int'(d0_scr_x); obs[3] = int'(d0_scr_y);
            obs[12] = int'(d0_fc);
        end else begin
            obs[0] = int'(d1_hcnt);  obs[1] = int'(d1_vcnt);
            obs[2] = int'(d1_scr_x); obs[3] = int'(d1_scr_y);
            obs[12] = int'(d1_fc);
        end
        obs[4]  = int'(hblank[i]);      obs[5]  = int'(vblank[i]);
        obs[6]  = int'(hsync[i]);       obs[7]  = int'(vsync[i]);
        obs[8]  = int'(disp[i]);        obs[9]  = int'(line_start[i]);
        obs[10] = int'(frame_start[i]); obs[11] = int'(vbl_irq[i]);
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("d%0d.%s q=%0d", i, nm[k], q[i]), obs[k], exp[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        if (frame_start[1]) begin
            if (armed) begin
                chk("d1.lines_per_frame", ls_cnt, S_VT);
                chk("d1.vbl_irq_per_frame", vi_cnt, 1);
            end
            armed  = 1;
            ls_cnt = 0;
            vi_cnt = 0;
        end
        if (line_start[1]) ls_cnt++;
        if (vbl_irq[1]) vi_cnt++;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1;
            if (gap[i] == 0) begin
                ce[i]  = 1'b1;
                gap[i] = $urandom_range(0, gmax[i]);
            end else begin
                ce[i] = 1'b0;
                gap[i]--;
            end
            if (adj_rand[i]) begin
                hs_adj[i] = 4'($urandom);
                vs_adj[i] = 3'($urandom);
            end
            if ($urandom_range(0, 31) == 0) flip[i] = ~flip[i];
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            drive();
            tick();
        end
    endtask

    initial begin
        HT  = '{424, S_HT};  HA  = '{288, S_HA};
        HSS = '{320, S_HSS}; HSL = '{32,  S_HSL};
        VT  = '{262, S_VT};  VA  = '{224, S_VA};
        VSS = '{236, S_VSS}; VSL = '{3,   S_VSL};
        rst_n = 2'b00; ce = 2'b00; flip = 2'b00;
        hs_adj[0] = '0; hs_adj[1] = '0; vs_adj[0] = '0; vs_adj[1] = '0;
        gap = '{0, 0}; gmax = '{0, 0}; adj_rand = '{1, 1};

        repeat (3) tick();

        // Continuous ce; full-size instance gets a one-clk reset mid-line.
        for (int c = 0; c < 1400; c++) begin
            drive();
            if (c > 500 && q[0] == 424 + 150 && !fresh[0]) rst_n[0] = 1'b0;
            tick();
        end

        // Random ce gaps.
        gmax = '{3, 20};
        run(3000);

        // Extreme trims held over whole frames: both clamp directions.
        gmax = '{0, 0};
        gap  = '{0, 0};
        adj_rand[1] = 0;
        hs_adj[1] = 4'b1000;
        vs_adj[1] = 3'b011;
        run(1700);
        hs_adj[1] = 4'b0111;
        vs_adj[1] = 3'b100;
        run(1700);

        // Random trims, then a mid-frame reset of the small instance.
        adj_rand[1] = 1;
        run(500);
        drive();
        rst_n[1] = 1'b0;
        armed = 0;
        tick();
        run(1200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
